// File: rtl/axi_rd_arb_if.sv
// ---------------------------------------------------------------------------
// axi_rd_arb_if
// Bundles the refill-port side (requests and return beats) and the AXI read
// channels of axi_rd_arb into one interface.
//   master : the arbiter, which is the AXI read master and answers the ports
//   slave  : the environment, meaning the refill ports and the AXI read slave
// NPORT must match the NPORT of the axi_rd_arb instance it is connected to.
// ---------------------------------------------------------------------------
interface axi_rd_arb_if #(
  parameter int NPORT = 3
);

  // Refill-port request side; port i occupies slice i of each flat vector
  logic [NPORT-1:0]    rd_req;
  logic [3*NPORT-1:0]  rd_type;
  logic [32*NPORT-1:0] rd_addr;
  logic [NPORT-1:0]    rd_rdy;

  // Refill-port return side; data and last are broadcast to every port
  logic [NPORT-1:0]    ret_valid;
  logic                ret_last;
  logic [31:0]         ret_data;

  // AXI read address channel
  logic [3:0]          arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  // AXI read data channel
  logic [3:0]          rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    input  rd_req, rd_type, rd_addr,
    output rd_rdy, ret_valid, ret_last, ret_data,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output rd_req, rd_type, rd_addr,
    input  rd_rdy, ret_valid, ret_last, ret_data,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_rd_arb.sv
// ---------------------------------------------------------------------------
// axi_rd_arb
// Merges NPORT cache-style refill ports onto a single AXI read channel.
// Each port may have one read outstanding. Requests are tagged with
// arid = port index, so returns for different ports may interleave and are
// steered back by rid alone.
//
// Configuration macro:
//   AXI_RD_ARB_RR_EN  defined   -> round-robin arbitration with a pointer
//                     undefined -> fixed priority, lowest index wins
// ---------------------------------------------------------------------------
module axi_rd_arb #(
  parameter int NPORT      = 3,   // 1..16
  parameter int LINE_BEATS = 4    // power of two, 2..16
) (
  input  logic            aclk,
  input  logic            areset,
  axi_rd_arb_if.master    bus,
  output logic            err
);

  // -------------------------------------------------------------------------
  // Constants and types
  // -------------------------------------------------------------------------
  localparam int          PW        = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int          LINE_OFFS = $clog2(LINE_BEATS) + 2;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << LINE_OFFS) - 32'd1);
  localparam logic [7:0]  LINE_LEN  = 8'(LINE_BEATS - 1);
  localparam logic [2:0]  TYPE_LINE = 3'b100;

  typedef enum logic {
    P_IDLE,
    P_BUSY
  } port_state_e;

  typedef enum logic {
    AR_EMPTY,
    AR_FULL
  } ar_state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  port_state_e port_q [NPORT];
  port_state_e port_d [NPORT];

  ar_state_e   ar_q, ar_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;

  logic        err_q, err_d;

  // -------------------------------------------------------------------------
  // Per-port decode of the return channel
  // -------------------------------------------------------------------------
  logic [NPORT-1:0] busy;      // port has a read outstanding
  logic [NPORT-1:0] hit;       // current beat belongs to a busy port
  logic [NPORT-1:0] done;      // current beat is the last one of that port
  logic [NPORT-1:0] eligible;  // port may be granted this cycle
  logic [NPORT-1:0] grant;     // one-hot or zero
  logic             grant_any;
  logic [PW-1:0]    win;       // index of the granted port

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign busy[gi] = (port_q[gi] == P_BUSY);
    assign hit[gi]  = bus.rvalid & (bus.rid == 4'(gi)) & busy[gi];
    assign done[gi] = hit[gi] & bus.rlast;
  end

  // A port can only be granted while idle and while the single AR holding
  // register has room. Nothing here looks at an AXI input, so rd_rdy never
  // depends combinationally on arready or the R channel.
  assign eligible = bus.rd_req & ~busy & {NPORT{ar_q == AR_EMPTY}};

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
`ifdef AXI_RD_ARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;

  // Round-robin: search from the pointer upwards, then wrap to index 0
  always_comb begin : arb_comb
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    grant     = '0;
    grant_any = 1'b0;
    win       = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (!grant_any && eligible[j] && (j >= int'(ptr_q))) begin
        grant[j]  = 1'b1;
        grant_any = 1'b1;
        win       = PW'(j);
      end
    end
    for (int j = 0; j < NPORT; j++) begin
      if (!grant_any && eligible[j]) begin
        grant[j]  = 1'b1;
        grant_any = 1'b1;
        win       = PW'(j);
      end
    end
  end

  // Pointer moves to the slot after the winner on every grant
  always_comb begin : ptr_comb
    ptr_d = ptr_q;
    if (grant_any) begin
      if (int'(win) == NPORT - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win + 1'b1;
      end
    end
  end

  // Round-robin pointer register
  always_ff @(posedge aclk or posedge areset) begin : ptr_ff
    if (areset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: the lowest eligible index wins
  always_comb begin : arb_comb
    grant     = '0;
    grant_any = 1'b0;
    win       = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (!grant_any && eligible[j]) begin
        grant[j]  = 1'b1;
        grant_any = 1'b1;
        win       = PW'(j);
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Winner's request fields
  // -------------------------------------------------------------------------
  logic [2:0]  sel_type;
  logic [31:0] sel_addr;

  // Select type and address of the granted port (don't-care when no grant)
  always_comb begin : sel_comb
    sel_type = '0;
    sel_addr = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (grant[j]) begin
        sel_type = bus.rd_type[3*j +: 3];
        sel_addr = bus.rd_addr[32*j +: 32];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-port FSMs
  // -------------------------------------------------------------------------
  // Next state of each port: busy from grant until its own rlast. A port
  // that sees rlast is still busy in that cycle, so it cannot be re-granted
  // until the following cycle.
  always_comb begin : port_comb
    for (int j = 0; j < NPORT; j++) begin
      port_d[j] = port_q[j];
      unique case (port_q[j])
        P_IDLE: if (grant[j]) port_d[j] = P_BUSY;
        P_BUSY: if (done[j])  port_d[j] = P_IDLE;
        default:              port_d[j] = P_IDLE;
      endcase
    end
  end

  // Port state registers
  always_ff @(posedge aclk or posedge areset) begin : port_ff
    if (areset) begin
      for (int j = 0; j < NPORT; j++) begin
        port_q[j] <= P_IDLE;
      end
    end else begin
      for (int j = 0; j < NPORT; j++) begin
        port_q[j] <= port_d[j];
      end
    end
  end

  // -------------------------------------------------------------------------
  // AR holding register
  // -------------------------------------------------------------------------
  // Load on grant, drain on handshake. The fields are written only on a
  // grant, so they hold steady for as long as arvalid waits on arready.
  always_comb begin : ar_comb
    ar_d     = ar_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arsize_d = arsize_q;
    unique case (ar_q)
      AR_EMPTY: begin
        if (grant_any) begin
          ar_d   = AR_FULL;
          arid_d = 4'(win);
          if (sel_type == TYPE_LINE) begin
            araddr_d = sel_addr & LINE_MASK;
            arlen_d  = LINE_LEN;
            arsize_d = 3'd2;
          end else begin
            araddr_d = sel_addr;
            arlen_d  = 8'd0;
            arsize_d = {1'b0, sel_type[1:0]};
          end
        end
      end
      AR_FULL: begin
        if (bus.arready) ar_d = AR_EMPTY;
      end
      default: ar_d = AR_EMPTY;
    endcase
  end

  // AR register state and payload
  always_ff @(posedge aclk or posedge areset) begin : ar_ff
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values and the order of statements cannot matter.
    if (areset) begin
      ar_q     <= AR_EMPTY;
      arid_q   <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
    end else begin
      ar_q     <= ar_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arsize_q <= arsize_d;
    end
  end

  // -------------------------------------------------------------------------
  // Protocol error
  // -------------------------------------------------------------------------
  // Any valid beat that no busy port claims is an error: rid beyond NPORT or
  // aimed at an idle port. Such a beat is dropped and the flag sticks.
  always_comb begin : err_comb
    err_d = err_q | (bus.rvalid & ~(|hit));
  end

  // Sticky error register, cleared only by reset
  always_ff @(posedge aclk or posedge areset) begin : err_ff
    if (areset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.rd_rdy    = grant;
  assign bus.ret_valid = hit;
  assign bus.ret_last  = bus.rlast;
  assign bus.ret_data  = bus.rdata;

  assign bus.arvalid   = (ar_q == AR_FULL);
  assign bus.arid      = arid_q;
  assign bus.araddr    = araddr_q;
  assign bus.arlen     = arlen_q;
  assign bus.arsize    = arsize_q;
  assign bus.arburst   = 2'b01;
  assign bus.arlock    = 2'b00;
  assign bus.arcache   = 4'b0000;
  assign bus.arprot    = 3'b000;

  // Every beat is accepted; rresp carries no information used here
  assign bus.rready    = 1'b1;

  assign err           = err_q;

endmodule
